// File: rtl/rep_link_pkg.sv
// Shared definitions for the repetition-coded serial link (transmit and receive ends).
package rep_link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rep_state_e;

    localparam int unsigned REP_DEFAULT    = 3;
    localparam int unsigned DATA_W_DEFAULT = 8;

    // Samples per frame: every data bit (plus optional parity bit) repeated rep times.
    function automatic int unsigned rep_frame_len(input int unsigned data_w,
                                                  input int unsigned rep,
                                                  input bit          parity);
        return (data_w + (parity ? 32'd1 : 32'd0)) * rep;
    endfunction

endpackage

// File: rtl/rep_slot_timer.sv
// Modulo-REP sample counter; tc_c_o flags the last repetition of the current bit.
module rep_slot_timer
    import rep_link_pkg::*;
#(
    parameter int unsigned REP = REP_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_c_o
);

    localparam int unsigned CNT_W = (REP > 1) ? $clog2(REP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REP - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_c_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rep_vote_tx.sv
// Repetition-coded serial transmitter: LSB-first, each bit held for REP samples.
// Optional even-parity slot appended when REP_VOTE_TX_PARITY_EN is defined.
module rep_vote_tx
    import rep_link_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned REP    = REP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              tx_en,
    output logic              tx_sof,
    output logic              busy
);

`ifdef REP_VOTE_TX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W + PAR_BITS - 1);

    rep_state_e        state_q,   state_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [DATA_W-1:0] shift_nxt;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              ready_q,   ready_d;
    logic              busy_q,    busy_d;
    logic              tx_out_q,  tx_out_d;
    logic              tx_en_q,   tx_en_d;
    logic              tx_sof_q,  tx_sof_d;
    logic              timer_clr;
    logic              timer_en;
    logic              slot_tc;
`ifdef REP_VOTE_TX_PARITY_EN
    logic              parity_q,  parity_d;
`endif

    rep_slot_timer #(
        .REP (REP)
    ) u_slot_timer (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .tc_c_o (slot_tc)
    );

    // Parity rides in at the top so it lands in bit 0 after the last data bit.
    always_comb begin
        shift_nxt = shift_q >> 1;
`ifdef REP_VOTE_TX_PARITY_EN
        shift_nxt[DATA_W-1] = parity_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        ready_d   = ready_q;
        tx_out_d  = 1'b0;
        tx_en_d   = 1'b0;
        tx_sof_d  = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
`ifdef REP_VOTE_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (valid_in && ready_q) begin
                    state_d   = SEND;
                    shift_d   = data_in;
                    bit_idx_d = '0;
                    ready_d   = 1'b0;
                    timer_clr = 1'b1;
                    tx_out_d  = data_in[0];
                    tx_en_d   = 1'b1;
                    tx_sof_d  = 1'b1;
`ifdef REP_VOTE_TX_PARITY_EN
                    parity_d  = ^data_in;
`endif
                end
            end
            SEND: begin
                timer_en = 1'b1;
                tx_en_d  = 1'b1;
                tx_out_d = shift_q[0];
                if (slot_tc) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d  = IDLE;
                        ready_d  = 1'b1;
                        tx_en_d  = 1'b0;
                        tx_out_d = 1'b0;
                    end else begin
                        shift_d   = shift_nxt;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_out_d  = shift_nxt[0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
        busy_d = ~ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            tx_out_q  <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_sof_q  <= 1'b0;
`ifdef REP_VOTE_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            tx_out_q  <= tx_out_d;
            tx_en_q   <= tx_en_d;
            tx_sof_q  <= tx_sof_d;
`ifdef REP_VOTE_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign ready_out = ready_q;
    assign busy      = busy_q;
    assign tx_out    = tx_out_q;
    assign tx_en     = tx_en_q;
    assign tx_sof    = tx_sof_q;

endmodule

// File: tb/tb_rep_vote_tx.sv
// Self-checking bench for rep_vote_tx (DATA_W=8, REP=3); honours REP_VOTE_TX_PARITY_EN.
module tb_rep_vote_tx;
    import rep_link_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned REP = 3;
`ifdef REP_VOTE_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int unsigned FL = rep_frame_len(DW, REP, PAR);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_out, tx_out, tx_en, tx_sof, busy;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [63:0]   seq;

    rep_vote_tx #(.DATA_W(DW), .REP(REP)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx_out    (tx_out),
        .tx_en     (tx_en),
        .tx_sof    (tx_sof),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            exp_pop;
        bit            mutate;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: sample k carries bit k/REP of the word, or the even parity of the word.
    function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
        int idx;
        idx = k / REP;
        if (idx < int'(DW)) return w[idx];
        return ^w;
    endfunction

    task automatic check_idle(input string nm);
        chk({nm, "_ready"}, 32'(ready_out), 32'd1);
        chk({nm, "_busy"},  32'(busy),      32'd0);
        chk({nm, "_en"},    32'(tx_en),     32'd0);
        chk({nm, "_out"},   32'(tx_out),    32'd0);
        chk({nm, "_sof"},   32'(tx_sof),    32'd0);
    endtask

    // Present a word for one accept edge; lands on the first sample.
    task automatic start(input logic [DW-1:0] w, input bit keep_valid);
        valid_in = 1'b1;
        data_in  = w;
        @(negedge clk);
        if (!keep_valid) valid_in = 1'b0;
    endtask

    // Walk a whole frame plus the gap cycle after it.
    task automatic frame_check(input logic [DW-1:0] w, input bit mutate, output int ones);
        ones = 0;
        seq  = '0;
        for (int k = 0; k < int'(FL); k++) begin
            chk("frame_en",    32'(tx_en),     32'd1);
            chk("frame_sof",   32'(tx_sof),    32'(k == 0));
            chk("frame_bit",   32'(tx_out),    32'(exp_bit(w, k)));
            chk("frame_ready", 32'(ready_out), 32'd0);
            chk("frame_busy",  32'(busy),      32'd1);
            seq[k] = tx_out;
            ones  += int'(tx_out);
            if (mutate) begin
                data_in  = DW'($urandom);
                valid_in = 1'($urandom);
            end
            @(negedge clk);
        end
        check_idle("gap");
    endtask

    vec_t vecs[7];
    int   ones;

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("idle_hold");
        end

        vecs[0] = '{data: 8'hA5, exp_pop: 4, mutate: 1'b0};
        vecs[1] = '{data: 8'h3C, exp_pop: 4, mutate: 1'b0};
        vecs[2] = '{data: 8'h01, exp_pop: 1, mutate: 1'b0};
        vecs[3] = '{data: 8'h80, exp_pop: 1, mutate: 1'b0};
        vecs[4] = '{data: 8'hFF, exp_pop: 8, mutate: 1'b0};
        vecs[5] = '{data: 8'h00, exp_pop: 0, mutate: 1'b0};
        vecs[6] = '{data: 8'h5A, exp_pop: 4, mutate: 1'b1};
        foreach (vecs[i]) begin
            start(vecs[i].data, 1'b0);
            frame_check(vecs[i].data, vecs[i].mutate, ones);
            chk("table_ones", 32'(ones),
                32'(vecs[i].exp_pop * int'(REP) +
                    ((PAR && (vecs[i].exp_pop % 2 == 1)) ? int'(REP) : 0)));
            valid_in = 1'b0;
            @(negedge clk);
            check_idle("table_after");
        end

        // Literal 0xA5 sample pattern
        start(8'hA5, 1'b0);
        frame_check(8'hA5, 1'b0, ones);
`ifndef REP_VOTE_TX_PARITY_EN
        chk("a5_pattern", seq[31:0], 32'h00E381C7);
`endif
        @(negedge clk);

        // Back-to-back with valid held: second accept on first ready cycle
        start(8'hFF, 1'b1);
        frame_check(8'hFF, 1'b0, ones);
        data_in = 8'h00;
        @(negedge clk);
        valid_in = 1'b0;
        frame_check(8'h00, 1'b0, ones);
        chk("b2b_zeros", 32'(ones), 32'd0);
        @(negedge clk);

        // Reset during the 10th sample aborts the frame
        start(8'h3C, 1'b0);
        for (int k = 0; k < 9; k++) begin
            chk("abort_bit", 32'(tx_out), 32'(exp_bit(8'h3C, k)));
            @(negedge clk);
        end
        chk("abort_en_before", 32'(tx_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle("abort_after");
        end

`ifdef REP_VOTE_TX_PARITY_EN
        start(8'h07, 1'b0);
        frame_check(8'h07, 1'b0, ones);
        chk("par_07_tail", 32'(seq[26:24]), 32'd7);
        @(negedge clk);
        start(8'h03, 1'b0);
        frame_check(8'h03, 1'b0, ones);
        chk("par_03_tail", 32'(seq[26:24]), 32'd0);
        @(negedge clk);
`endif

        // Randomized frames, with random mid-frame input noise and idle gaps
        for (int n = 0; n < 24; n++) begin
            logic [DW-1:0] w;
            bit            mut;
            int            gap;
            w   = DW'($urandom);
            mut = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 3));
            start(w, 1'b0);
            frame_check(w, mut, ones);
            valid_in = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_idle("rand_gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
